// File: rtl/ct_frame_accumulator.sv
// Frame accumulator behind the 6-bit two-column compressor tree: it registers the
// per-beat weighted column sum and totals it over FRAME_LEN beats.
module ct_frame_accumulator #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [5:0]       in_a_i,
    input  logic [5:0]       in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic             out_ovf_o
);

    localparam int unsigned COL_W = 6;
    localparam int unsigned S_W   = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic logic [2:0] popcount6(input logic [COL_W-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < COL_W; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic [S_W-1:0]   s1_sum_q, s1_sum_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             beat_fire_c;
    logic [S_W-1:0]   beat_sum_c;
    logic [SUM_W-1:0] acc_sum_c;

    // Weight-2 column contributes twice its popcount.
    assign beat_sum_c  = S_W'(popcount6(in_a_i)) + S_W'({popcount6(in_b_i), 1'b0});
    assign beat_fire_c = in_valid_i && in_ready_q;
    assign acc_sum_c   = SUM_W'(acc_q) + SUM_W'(s1_sum_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            beat_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        s1_valid_d  = beat_fire_c;
        s1_sum_d    = beat_fire_c ? beat_sum_c : s1_sum_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        // Stage 2: fold the registered beat sum in; the carry out is sticky per frame.
        if (s1_valid_q) begin
            acc_d = acc_sum_c[ACC_W-1:0];
            ovf_d = ovf_q | acc_sum_c[ACC_W];
        end

        case (state_q)
            ST_ACC: begin
                if (beat_fire_c) begin
                    if (beat_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d    = ST_DRAIN;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                state_d     = ST_HOLD;
                out_valid_d = 1'b1;
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                end
            end
            default: begin
                state_d     = ST_ACC;
                out_valid_d = 1'b0;
            end
        endcase

        // Registered ready: follows the state being entered, never in_valid.
        in_ready_d = (state_d == ST_ACC);
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = acc_q;
    assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_ct_frame_accumulator.sv
// Directed, table-driven bench for ct_frame_accumulator: two FRAME_LEN=8 instances
// (ACC_W=16 and ACC_W=7) share stimulus; a FRAME_LEN=1 instance checks per-beat sums.
module tb_ct_frame_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid, out_ready;
    logic [5:0]  in_a, in_b;
    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [15:0] out_sum_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [6:0]  out_sum_b;

    logic        c_in_valid, c_out_ready;
    logic [5:0]  c_in_a, c_in_b;
    logic        c_in_ready, c_out_valid, c_out_ovf;
    logic [15:0] c_out_sum;

    ct_frame_accumulator #(.FRAME_LEN(8), .ACC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_a_i(in_a), .in_b_i(in_b),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready),
        .out_sum_o(out_sum_a), .out_ovf_o(out_ovf_a)
    );

    ct_frame_accumulator #(.FRAME_LEN(8), .ACC_W(7)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_a_i(in_a), .in_b_i(in_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready),
        .out_sum_o(out_sum_b), .out_ovf_o(out_ovf_b)
    );

    ct_frame_accumulator #(.FRAME_LEN(1), .ACC_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_a_i(c_in_a), .in_b_i(c_in_b),
        .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
        .out_sum_o(c_out_sum), .out_ovf_o(c_out_ovf)
    );

    typedef struct {
        string           name;
        logic [7:0][5:0] a;
        logic [7:0][5:0] b;
        int              gap;
        int              hold;
        int              exp_sum;
        int              exp_sum7;
        logic            exp_ovf7;
    } frame_t;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        int         exp;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [5:0] a, input logic [5:0] b, output int acc_cyc);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready_a && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready_a) begin
            check("beat_accept_timeout", 32'(in_ready_a), 1);
            in_valid = 1'b0;
            acc_cyc  = cyc;
            return;
        end
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input frame_t f);
        int t, t_first, t_last;
        t_first = 0;
        t_last  = 0;
        for (int i = 0; i < 8; i++) begin
            repeat (i == 0 ? 0 : f.gap) tick();
            send_beat(f.a[i], f.b[i], t);
            if (i == 0) t_first = t;
            t_last = t;
        end
        check({f.name, "_span"}, 32'(t_last - t_first), 32'(7 * (f.gap + 1)));
        check({f.name, "_drain_valid"}, 32'(out_valid_a), 0);
        check({f.name, "_drain_ready"}, 32'(in_ready_a), 0);
        tick();
        check({f.name, "_valid_a"}, 32'(out_valid_a), 1);
        check({f.name, "_valid_b"}, 32'(out_valid_b), 1);
        check({f.name, "_sum_a"}, 32'(out_sum_a), 32'(f.exp_sum));
        check({f.name, "_ovf_a"}, 32'(out_ovf_a), 0);
        check({f.name, "_sum_b"}, 32'(out_sum_b), 32'(f.exp_sum7));
        check({f.name, "_ovf_b"}, 32'(out_ovf_b), 32'(f.exp_ovf7));
        check({f.name, "_hold_ready"}, 32'(in_ready_a), 0);
        for (int h = 0; h < f.hold; h++) begin
            tick();
            check({f.name, "_stall_valid"}, 32'(out_valid_a), 1);
            check({f.name, "_stall_sum"}, 32'(out_sum_a), 32'(f.exp_sum));
            check({f.name, "_stall_ready"}, 32'(in_ready_b), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({f.name, "_post_valid"}, 32'(out_valid_a), 0);
        check({f.name, "_post_ready"}, 32'(in_ready_a), 1);
        check({f.name, "_post_sum"}, 32'(out_sum_a), 0);
        check({f.name, "_post_ovf_b"}, 32'(out_ovf_b), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int waited;
        string nm;
        nm = $sformatf("beat%0d", idx);
        waited = 0;
        c_in_valid = 1'b1;
        c_in_a     = v.a;
        c_in_b     = v.b;
        while (!c_in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check({nm, "_ready"}, 32'(c_in_ready), 1);
        tick();
        c_in_valid = 1'b0;
        check({nm, "_drain_valid"}, 32'(c_out_valid), 0);
        tick();
        check({nm, "_valid"}, 32'(c_out_valid), 1);
        check({nm, "_sum"}, 32'(c_out_sum), 32'(v.exp));
        check({nm, "_ovf"}, 32'(c_out_ovf), 0);
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        check({nm, "_post_valid"}, 32'(c_out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        frame_t frames[5];
        vec_t   vecs[10];
        int     t;

        frames[0] = '{"allones", {8{6'h3F}}, {8{6'h3F}}, 0, 0, 144, 16, 1'b1};
        frames[1] = '{"zeros",   {8{6'h00}}, {8{6'h00}}, 0, 0, 0, 0, 1'b0};
        frames[2] = '{"mixed",
                      {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h15, 6'h00, 6'h01},
                      {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h2A, 6'h01, 6'h00},
                      0, 0, 12, 12, 1'b0};
        frames[3] = '{"toggle",  {8{6'h3F}}, {8{6'h3F}}, 1, 0, 144, 16, 1'b1};
        frames[4] = '{"stall",   {8{6'h07}}, {8{6'h00}}, 0, 5, 24, 24, 1'b0};

        vecs[0] = '{6'h3F, 6'h3F, 18};
        vecs[1] = '{6'h01, 6'h00, 1};
        vecs[2] = '{6'h00, 6'h01, 2};
        vecs[3] = '{6'h15, 6'h2A, 9};
        vecs[4] = '{6'h00, 6'h00, 0};
        vecs[5] = '{6'h3F, 6'h00, 6};
        vecs[6] = '{6'h00, 6'h3F, 12};
        vecs[7] = '{6'h01, 6'h20, 3};
        vecs[8] = '{6'h2A, 6'h15, 9};
        vecs[9] = '{6'h0F, 6'h30, 8};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_a        = '0;
        in_b        = '0;
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        c_in_a      = '0;
        c_in_b      = '0;

        tick();
        tick();
        check("rst_ready", 32'(in_ready_a), 0);
        check("rst_valid", 32'(out_valid_a), 0);
        check("rst_sum", 32'(out_sum_a), 0);
        check("rst_ovf_b", 32'(out_ovf_b), 0);
        check("rst_c_valid", 32'(c_out_valid), 0);
        rst_n = 1'b1;
        tick();
        check("rst_release_ready", 32'(in_ready_a), 1);

        for (int i = 0; i < 5; i++) begin
            run_frame(frames[i]);
            tick();
        end

        // Reset mid-frame must discard the partial sum and beat count.
        for (int i = 0; i < 4; i++) send_beat(6'h3F, 6'h3F, t);
        rst_n = 1'b0;
        tick();
        check("midrst_ready", 32'(in_ready_a), 0);
        check("midrst_valid", 32'(out_valid_a), 0);
        check("midrst_sum_a", 32'(out_sum_a), 0);
        check("midrst_sum_b", 32'(out_sum_b), 0);
        check("midrst_ovf_a", 32'(out_ovf_a), 0);
        rst_n = 1'b1;
        tick();
        frames[4].name = "after_rst";
        frames[4].hold = 0;
        run_frame(frames[4]);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
